shift_sub_divider: RTL and testbench

- Sequential restoring divider: the inverse of the combinational 11-bit × 3-bit shift-add multiplier.
- Divides a 14-bit dividend by a 3-bit divisor and returns an 11-bit quotient and a 3-bit remainder.
- Used in the distance path to recover a value from a scaled product, e.g. dividing a scaled baseline term by a small disparity factor.
- Processes one quotient bit per clock with a start/done handshake.

---
 rtl/shift_sub_divider.sv | 151 +++++++++++++++
 tb/tb_shift_sub_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: DW-bit dividend / SW-bit divisor, one quotient bit per clock.
// Optional macro DIV_ROUND_EN: round quotient half up on completion (saturating).
`timescale 1ns/1ps

module shift_sub_divider #(
  parameter int unsigned DW = 14,
  parameter int unsigned QW = 11,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic [SW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int unsigned CW = $clog2(DW);
  localparam int unsigned PW = SW + 1;
  localparam logic [QW-1:0] QMAX = '1;
  localparam logic [DW:0]   QLIM = (DW+1)'((1 << QW) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DW-1:0] dvd_sr;
  logic [DW-1:0] quo_sr;
  // Stored remainder is always below the divisor, so SW bits suffice between steps.
  logic [SW-1:0] prem;
  logic [SW-1:0] dsr;
  logic [CW-1:0] cnt;
  logic          zero_pend;

  logic          accept;
  logic [PW-1:0] trial;
  logic          fits;
  logic [SW-1:0] prem_step;
  logic [DW-1:0] quo_step;
  logic          round_inc;
  logic [DW:0]   q_sum;
  logic          sat;
  logic [QW-1:0] res_q;

  // One restoring iteration plus final quotient saturation/rounding.
  always_comb begin
    trial     = {prem, dvd_sr[DW-1]};
    fits      = trial >= {1'b0, dsr};
    prem_step = fits ? SW'(trial - {1'b0, dsr}) : SW'(trial);
    quo_step  = {quo_sr[DW-2:0], fits};
    round_inc = 1'b0;
`ifdef DIV_ROUND_EN
    round_inc = {prem_step, 1'b0} >= {1'b0, dsr};
`endif
    q_sum = {1'b0, quo_step} + (DW+1)'(round_inc);
    sat   = q_sum > QLIM;
    res_q = sat ? QMAX : QW'(q_sum);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state; a zero divisor spends one CALC cycle so done lands one edge after start.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (zero_pend || (cnt == CW'(DW - 1))) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_sr      <= '0;
      quo_sr      <= '0;
      prem        <= '0;
      dsr         <= '0;
      cnt         <= '0;
      zero_pend   <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_sr      <= dividend;
            dsr         <= divisor;
            quo_sr      <= '0;
            prem        <= '0;
            cnt         <= '0;
            zero_pend   <= (divisor == '0);
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          if (zero_pend) begin
            quotient    <= QMAX;
            remainder   <= '0;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            dvd_sr <= {dvd_sr[DW-2:0], 1'b0};
            quo_sr <= quo_step;
            prem   <= prem_step;
            cnt    <= cnt + CW'(1);
            if (state_next == DONE) begin
              quotient  <= res_q;
              remainder <= prem_step;
              overflow  <= sat;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: arithmetic reference model plus directed literal cases.
`timescale 1ns/1ps

module tb_shift_sub_divider;

  localparam int unsigned DW = 14;
  localparam int unsigned QW = 11;
  localparam int unsigned SW = 3;
  localparam int QMAXI = (1 << QW) - 1;

`ifdef DIV_ROUND_EN
  localparam int Q13   = 3;
  localparam int OV_SAT = 1;
`else
  localparam int Q13   = 2;
  localparam int OV_SAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] dividend;
  logic [SW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [QW-1:0] quotient;
  logic [SW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  shift_sub_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: operation timing as edge counts, results from integer division.
  bit m_armed = 0, m_busy = 0, m_done = 0, m_valid = 0;
  int m_left = 0;
  int p_q, p_r, p_dz, p_ov;
  int e_q = 0, e_r = 0, e_dz = 0, e_ov = 0;

  task automatic model_div(input int n, input int d);
    int qt;
    if (d == 0) begin
      p_q = QMAXI; p_r = 0; p_dz = 1; p_ov = 0;
    end else begin
      qt  = n / d;
      p_r = n % d;
`ifdef DIV_ROUND_EN
      if (2 * p_r >= d) qt++;
`endif
      p_dz = 0;
      if (qt > QMAXI) begin p_q = QMAXI; p_ov = 1; end
      else begin p_q = qt; p_ov = 0; end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_armed = 1; m_busy = 0; m_done = 0; m_left = 0; m_valid = 1;
      e_q = 0; e_r = 0; e_dz = 0; e_ov = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1; m_valid = 1;
        e_q = p_q; e_r = p_r; e_dz = p_dz; e_ov = p_ov;
      end
    end else if (start) begin
      m_busy  = 1;
      m_left  = (divisor == '0) ? 1 : DW;
      m_valid = 0;
      model_div(int'(dividend), int'(divisor));
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_valid) begin
        chk("quotient", quotient, e_q);
        chk("remainder", remainder, e_r);
        chk("div_by_zero", div_by_zero, e_dz);
        chk("overflow", overflow, e_ov);
      end
    end
  end

  // Start one operation, scramble operands after capture, wait (bounded) for done.
  task automatic run_op(input string name, input logic [DW-1:0] n, input logic [SW-1:0] d,
                        input int lat, input int eq, input int er, input int edz, input int eov,
                        input int poke_at);
    int e0;
    bit got;
    got = 0;
    @(posedge clk); #1;
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    e0 = cyc;
    start = 1'b0; dividend = ~n; divisor = d + 3'd1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; break; end
      if (i == poke_at) begin start = 1'b1; dividend = 14'd100; divisor = 3'd3; end
      else start = 1'b0;
    end
    start = 1'b0;
    chk({name, "_done_seen"}, got, 1);
    if (got) begin
      chk({name, "_latency"}, cyc - e0, lat);
      chk({name, "_q"}, quotient, eq);
      chk({name, "_r"}, remainder, er);
      chk({name, "_dz"}, div_by_zero, edz);
      chk({name, "_ov"}, overflow, eov);
    end
  endtask

  initial begin
    int t1, t2;
    bit got;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_q", quotient, 0);

    run_op("d9339_7",   14'd9339,  3'd7, 14, 1334, 1, 0, 0, -1);
    run_op("d7500_5",   14'd7500,  3'd5, 14, 1500, 0, 0, 0, -1);
    run_op("d16383_1",  14'd16383, 3'd1, 14, QMAXI, 0, 0, 1, -1);
    run_op("d1234_0",   14'd1234,  3'd0, 1,  QMAXI, 0, 1, 0, -1);
    run_op("d13_5",     14'd13,    3'd5, 14, Q13, 3, 0, 0, -1);
    run_op("d14335_7",  14'd14335, 3'd7, 14, QMAXI, 6, 0, OV_SAT, -1);
    run_op("d14336_7",  14'd14336, 3'd7, 14, QMAXI, 0, 0, 1, -1);
    run_op("d0_3",      14'd0,     3'd3, 14, 0, 0, 0, 0, -1);
    run_op("d100_7",    14'd100,   3'd7, 14, 14, 2, 0, 0, -1);
    run_op("mid_start", 14'd9339,  3'd7, 14, 1334, 1, 0, 0, 5);

    // Abort at iteration 6 with reset, then a normal operation.
    @(posedge clk); #1;
    start = 1'b1; dividend = 14'd7500; divisor = 3'd5;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    run_op("after_abort", 14'd7500, 3'd5, 14, 1500, 0, 0, 0, -1);

    // Start held high: back-to-back results every DW+2 cycles.
    @(posedge clk); #1;
    start = 1'b1; dividend = 14'd100; divisor = 3'd7;
    t1 = 0; t2 = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; t1 = cyc; break; end
    end
    chk("held_first", got, 1);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; t2 = cyc; break; end
    end
    start = 1'b0;
    chk("held_second", got, 1);
    chk("held_gap", t2 - t1, DW + 2);
    chk("held_q", quotient, 14);

    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
